// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared MDU types for the iterative divider
package mdu_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_type_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_e;

endpackage

// File: rtl/iter_divider_if.sv
// rtl/iter_divider_if.sv - request/result bundle between execute stage and divider
interface iter_divider_if #(
    parameter int XLEN = 32
);
    import mdu_pkg::*;

    logic [XLEN-1:0] divisor;
    logic [XLEN-1:0] dividend;
    logic            div_in_valid;
    div_type_e       div_type;
    logic            cpu_busy;
    logic [XLEN-1:0] div_out;
    logic            div_out_valid;
    logic            div_busy;

    modport master (
        output divisor, dividend, div_in_valid, div_type, cpu_busy,
        input  div_out, div_out_valid, div_busy
    );

    modport slave (
        input  divisor, dividend, div_in_valid, div_type, cpu_busy,
        output div_out, div_out_valid, div_busy
    );

endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] dvsr_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] shifted;
    logic          fits;

    // The shifted remainder needs one extra bit; once the trial subtract
    // succeeds the difference is below the divisor and fits in XLEN bits.
    always_comb begin
        shifted = {rem_i, quo_i[XLEN-1]};
        fits    = (shifted >= {1'b0, dvsr_i});
        rem_o   = fits ? (shifted[XLEN-1:0] - dvsr_i) : shifted[XLEN-1:0];
        quo_o   = {quo_i[XLEN-2:0], fits};
    end

endmodule

// File: rtl/iter_divider.sv
// rtl/iter_divider.sv - multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU
module iter_divider
    import mdu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    iter_divider_if.slave bus
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvsr_q, dvsr_d;
    logic [XLEN-1:0] res_q, res_d;
    logic            sel_rem_q, sel_rem_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic            spec_q, spec_d;
    logic [XLEN-1:0] out_q, out_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;

    logic            accept, is_signed, is_quo, div_zero, sovf, special;
    logic [XLEN-1:0] special_res, step_rem, step_quo, q_fix, r_fix;

    div_step #(.XLEN(XLEN)) u_step (
        .rem_i  (rem_q),
        .quo_i  (quo_q),
        .dvsr_i (dvsr_q),
        .rem_o  (step_rem),
        .quo_o  (step_quo)
    );

    // Divide-by-zero outranks signed overflow when both match.
    always_comb begin
        accept      = (state_q == IDLE) && bus.div_in_valid;
        is_signed   = (bus.div_type == DIV) || (bus.div_type == REM);
        is_quo      = (bus.div_type == DIV) || (bus.div_type == DIVU);
        div_zero    = (bus.divisor == '0);
        sovf        = is_signed && (bus.dividend == MIN_NEG) && (bus.divisor == '1);
        special     = div_zero || sovf;
        if (div_zero)
            special_res = is_quo ? '1 : bus.dividend;
        else
            special_res = is_quo ? bus.dividend : '0;
        q_fix = qneg_q ? -step_quo : step_quo;
        r_fix = rneg_q ? -step_rem : step_rem;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.div_in_valid) state_d = (special && EARLY_OUT) ? DONE : CALC;
            CALC:    if (cnt_q == '0) state_d = DONE;
            DONE:    if (!bus.cpu_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_d  = (state_q != IDLE);
        valid_d = (state_q == DONE);
        out_d   = valid_d ? res_q : '0;
    end

    // Operands are held as magnitudes; the minimum negative value negates
    // to itself, which is exactly its unsigned magnitude.
    always_comb begin
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        res_d     = res_q;
        sel_rem_d = sel_rem_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        spec_d    = spec_q;
        if (accept) begin
            cnt_d     = CW'(XLEN - 1);
            rem_d     = '0;
            quo_d     = (is_signed && bus.dividend[XLEN-1]) ? -bus.dividend : bus.dividend;
            dvsr_d    = (is_signed && bus.divisor[XLEN-1])  ? -bus.divisor  : bus.divisor;
            res_d     = special ? special_res : '0;
            sel_rem_d = !is_quo;
            qneg_d    = is_signed && (bus.dividend[XLEN-1] ^ bus.divisor[XLEN-1]);
            rneg_d    = is_signed && bus.dividend[XLEN-1];
            spec_d    = special;
        end else if (state_q == CALC) begin
            cnt_d = cnt_q - CW'(1);
            rem_d = step_rem;
            quo_d = step_quo;
            if ((cnt_q == '0) && !spec_q)
                res_d = sel_rem_q ? r_fix : q_fix;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            res_q     <= '0;
            sel_rem_q <= 1'b0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            spec_q    <= 1'b0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            res_q     <= res_d;
            sel_rem_q <= sel_rem_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            spec_q    <= spec_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.div_out       = out_q;
    assign bus.div_out_valid = valid_q;
    assign bus.div_busy      = busy_q;

endmodule

// File: tb/tb_iter_divider.sv
// tb/tb_iter_divider.sv - directed self-checking bench for iter_divider
module tb_iter_divider;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    div_type_e   op_t = DIVU;
    logic        cpu_busy = 1'b0;
    logic [2:0]  vld = '0;

    int n_pass = 0;
    int n_total = 0;

    logic [31:0] r_res;
    int          r_lat, r_vlen;
    logic        r_b0, r_b1;
    logic [31:0] r_after;
    int          held;
    logic        hold_ok, seen;

    always #5 clk = ~clk;

    iter_divider_if #(.XLEN(32)) if_a ();
    iter_divider_if #(.XLEN(32)) if_b ();
    iter_divider_if #(.XLEN(8))  if_c ();

    assign if_a.dividend = op_a;      assign if_a.divisor = op_b;
    assign if_a.div_type = op_t;      assign if_a.cpu_busy = cpu_busy;
    assign if_a.div_in_valid = vld[0];
    assign if_b.dividend = op_a;      assign if_b.divisor = op_b;
    assign if_b.div_type = op_t;      assign if_b.cpu_busy = cpu_busy;
    assign if_b.div_in_valid = vld[1];
    assign if_c.dividend = op_a[7:0]; assign if_c.divisor = op_b[7:0];
    assign if_c.div_type = op_t;      assign if_c.cpu_busy = cpu_busy;
    assign if_c.div_in_valid = vld[2];

    iter_divider #(.XLEN(32), .EARLY_OUT(1'b1)) u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    iter_divider #(.XLEN(32), .EARLY_OUT(1'b0)) u_b (.clk(clk), .rst(rst), .bus(if_b.slave));
    iter_divider #(.XLEN(8),  .EARLY_OUT(1'b1)) u_c (.clk(clk), .rst(rst), .bus(if_c.slave));

    function automatic logic get_valid(int s);
        case (s)
            0:       return if_a.div_out_valid;
            1:       return if_b.div_out_valid;
            default: return if_c.div_out_valid;
        endcase
    endfunction

    function automatic logic get_busy(int s);
        case (s)
            0:       return if_a.div_busy;
            1:       return if_b.div_busy;
            default: return if_c.div_busy;
        endcase
    endfunction

    function automatic logic [31:0] get_out(int s);
        case (s)
            0:       return if_a.div_out;
            1:       return if_b.div_out;
            default: return {24'd0, if_c.div_out};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Entered and left at #1 after a rising edge; the accept edge is edge 0.
    task automatic run_op(input int s, input div_type_e t, input logic [31:0] a, input logic [31:0] b);
        op_t = t; op_a = a; op_b = b;
        vld[s] = 1'b1;
        @(posedge clk); #1;
        vld[s] = 1'b0;
        r_b0 = get_busy(s);
        r_b1 = 1'b0; r_lat = -1; r_res = 'x; r_vlen = 0;
        for (int n = 1; n <= 60 && r_lat < 0; n++) begin
            @(posedge clk); #1;
            if (n == 1) r_b1 = get_busy(s);
            if (get_valid(s)) begin r_lat = n; r_res = get_out(s); end
        end
        while (r_lat >= 0 && get_valid(s) && r_vlen < 20) begin
            r_vlen++;
            @(posedge clk); #1;
        end
        r_after = get_out(s);
    endtask

    task automatic do_op(input string tag, input int s, input div_type_e t, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        run_op(s, t, a, b);
        chk({tag, "_res"}, r_res, exp);
        chk({tag, "_lat"}, r_lat, exp_lat);
    endtask

    initial begin
        #2;
        chk("rst_busy_a",  {31'd0, if_a.div_busy}, 32'd0);
        chk("rst_valid_a", {31'd0, if_a.div_out_valid}, 32'd0);
        chk("rst_out_a",   if_a.div_out, 32'd0);
        chk("rst_valid_c", {31'd0, if_c.div_out_valid}, 32'd0);
        #10 rst = 1'b0;
        @(posedge clk); #1;

        run_op(0, DIVU, 32'd100, 32'd7);
        chk("divu_100_7_res",   r_res, 32'd14);
        chk("divu_100_7_lat",   r_lat, 32'd33);
        chk("divu_busy_edge0",  {31'd0, r_b0}, 32'd0);
        chk("divu_busy_edge1",  {31'd0, r_b1}, 32'd1);
        chk("divu_valid_len",   r_vlen, 32'd1);
        chk("divu_out_cleared", r_after, 32'd0);
        do_op("remu_100_7",   0, REMU, 32'd100, 32'd7, 32'd2, 33);
        do_op("div_m7_2",     0, DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        do_op("rem_m7_2",     0, REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        do_op("rem_7_m2",     0, REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 33);
        do_op("div_min_2",    0, DIV,  32'h8000_0000, 32'd2, 32'hC000_0000, 33);
        do_op("div_min_3",    0, DIV,  32'h8000_0000, 32'd3, 32'hD555_5556, 33);
        do_op("rem_min_3",    0, REM,  32'h8000_0000, 32'd3, 32'hFFFF_FFFE, 33);
        do_op("divu_max_big", 0, DIVU, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 33);
        do_op("remu_max_big", 0, REMU, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 33);

        do_op("divu_5_0_eo",  0, DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        do_op("rem_5_0_eo",   0, REM,  32'd5, 32'd0, 32'd5, 1);
        do_op("div_ovf_eo",   0, DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        do_op("rem_ovf_eo",   0, REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        do_op("divu_5_0_it",  1, DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 33);
        do_op("rem_5_0_it",   1, REM,  32'd5, 32'd0, 32'd5, 33);
        do_op("div_m5_0_it",  1, DIV,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 33);
        do_op("rem_m5_0_it",  1, REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 33);
        do_op("div_ovf_it",   1, DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
        do_op("rem_ovf_it",   1, REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);

        cpu_busy = 1'b1;
        op_t = DIVU; op_a = 32'd1000; op_b = 32'd10; vld[0] = 1'b1;
        @(posedge clk); #1;
        op_a = 32'd50; op_b = 32'd5;
        r_lat = -1;
        for (int n = 1; n <= 60 && r_lat < 0; n++) begin
            @(posedge clk); #1;
            if (if_a.div_out_valid) r_lat = n;
        end
        chk("hold_lat", r_lat, 32'd33);
        held = 0; hold_ok = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (!if_a.div_out_valid) break;
            held++;
            if (if_a.div_out !== 32'd100) hold_ok = 1'b0;
            if (held == 5) begin cpu_busy = 1'b0; vld[0] = 1'b0; end
            @(posedge clk); #1;
        end
        cpu_busy = 1'b0; vld[0] = 1'b0;
        chk("hold_cycles", held, 32'd6);
        chk("hold_value",  {31'd0, hold_ok}, 32'd1);
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (if_a.div_out_valid || if_a.div_busy) seen = 1'b1;
        end
        chk("no_queued_op", {31'd0, seen}, 32'd0);
        do_op("reaccept_50_5", 0, DIVU, 32'd50, 32'd5, 32'd10, 33);

        op_t = DIVU; op_a = 32'd1000; op_b = 32'd7; vld[0] = 1'b1;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("busy_before_rst", {31'd0, if_a.div_busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_busy",  {31'd0, if_a.div_busy}, 32'd0);
        chk("midrst_valid", {31'd0, if_a.div_out_valid}, 32'd0);
        chk("midrst_out",   if_a.div_out, 32'd0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        do_op("post_rst_9_3", 0, DIVU, 32'd9, 32'd3, 32'd3, 33);

        do_op("x8_divu_200_13", 2, DIVU, 32'd200, 32'd13, 32'd15, 9);
        do_op("x8_remu_200_13", 2, REMU, 32'd200, 32'd13, 32'd5, 9);
        do_op("x8_div_m100_7",  2, DIV,  32'h9C, 32'd7, 32'hF2, 9);
        do_op("x8_div_ovf",     2, DIV,  32'h80, 32'hFF, 32'h80, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Parametrised multi-cycle radix-2 restoring divider for the RISC-V M-extension unit.
- Executes DIV/DIVU/REM/REMU on XLEN-bit operands.
- Sits beside the multiplier in the MDU and is driven by the execute stage.
- Holds its result until the CPU is no longer stalled (cpu_busy low).
- Generalises the 32-bit stub: configurable width, full RISC-V corner-case semantics, early completion for special cases.

Parameters:
- XLEN, 32, operand and result width in bits; any even value >= 4.
- EARLY_OUT, 1, when 1 divide-by-zero and signed overflow complete without iterating; when 0 they iterate normally but still produce the same spec results.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- divisor  input  XLEN  divisor operand (rs2)
- dividend  input  XLEN  dividend operand (rs1)
- div_in_valid  input  1  request strobe; operands and div_type sampled when accepted
- div_type  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- cpu_busy  input  1  consumer stalled; result must be held while high
- div_out  output  XLEN  quotient or remainder per latched div_type; 0 when div_out_valid low
- div_out_valid  output  1  result valid, registered
- div_busy  output  1  unit occupied, registered; new requests not accepted

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state IDLE, div_out 0, div_out_valid 0, div_busy 0, all internal registers 0.
- States:
  - IDLE, CALC, DONE.
  - IDLE: div_busy 0. On div_in_valid=1, latch dividend, divisor and div_type.
    - If a special case applies and EARLY_OUT=1: go to DONE with the result loaded.
    - Otherwise: go to CALC with the iteration counter = XLEN-1.
  - CALC: div_busy 1. Performs one restoring step per cycle (shift remainder:quotient left, trial-subtract |divisor|, set quotient bit if non-negative). Counter decrements; after the step at counter 0, apply sign fix-up and go to DONE.
  - DONE: div_busy 1, div_out_valid 1, div_out stable. Stay while cpu_busy=1. When cpu_busy=0, go to IDLE on the next edge, with div_out_valid and div_out cleared.
- Latency, with the accept edge as edge 0:
  - Normal ops: CALC for XLEN cycles; div_out_valid first high after edge XLEN+1 (XLEN=32: 33 cycles).
  - Special case with EARLY_OUT=1: valid after edge 1.
- Back-to-back requests: no new accept in the cycle DONE is exited; a new request is accepted in IDLE at the earliest. Throughput is one op per XLEN+2 cycles.
- div_in_valid while div_busy=1: ignored, not queued, no side effect.
- Signed ops (DIV, REM):
  - Operate on magnitudes.
  - Quotient is negated when the dividend and divisor signs differ.
  - Remainder takes the dividend's sign.
  - The XLEN-bit minimum value magnitude is handled as unsigned 2^(XLEN-1).
- Unsigned ops: operands used as-is, no fix-up.
- Divide by zero (all types):
  - Quotient = all ones (DIV and DIVU).
  - Remainder = dividend unmodified (REM and REMU).
- Signed overflow (dividend = 1 followed by XLEN-1 zeros, divisor = all ones, DIV/REM only):
  - Quotient = dividend.
  - Remainder = 0.
- Divide-by-zero check takes priority over the overflow check.
- Reset mid-operation: immediate return to IDLE and all outputs 0; the in-flight op is discarded.
- cpu_busy has no effect in IDLE or CALC.

Decomposition:
- Shared package mdu_pkg:
  - enum div_type_e {DIV=2'b00, DIVU=2'b01, REM=2'b10, REMU=2'b11}
  - enum div_state_e {IDLE, CALC, DONE}
- One natural sub-module: div_step, a combinational single restoring iteration.
  - Inputs: partial remainder, quotient shift register, |divisor|.
  - Outputs: next remainder and quotient.
  - Parametrised by XLEN.
  - Lets a future multi-bit-per-cycle variant instantiate it N times.
- Counter width: $clog2(XLEN).

Test Plan:
- DIVU 100/7, cpu_busy=0: div_busy high from edge 1, div_out=14 with div_out_valid at cycle 33, one cycle only; REMU same operands gives 2.
- DIV -7/2 gives 0xFFFFFFFD (-3); REM -7/2 gives 0xFFFFFFFF (-1); REM 7/-2 gives 1.
- DIVU 5/0 gives 0xFFFFFFFF; REM 5/0 gives 5. Both valid at cycle 1 with EARLY_OUT=1 and at cycle 33 with EARLY_OUT=0.
- DIV 0x80000000/0xFFFFFFFF gives 0x80000000; REM gives 0.
- DIVU 1000/10 with cpu_busy=1 for 5 cycles after valid: div_out=100 held 6 cycles; a second div_in_valid during CALC/DONE is ignored; re-accept occurs only from IDLE.
- Reset pulse at cycle 10 of CALC: outputs 0 immediately; the next request 9/3 returns 3 normally. Repeat DIVU 200/13 gives 15 on an XLEN=8 instance in 9 cycles.
